// File: rtl/pixel_sink_pkg.sv
// -----------------------------------------------------------------------------
// pixel_sink_pkg
//   Shared constants for the pixel_sink framebuffer:
//     - frame geometry (160 x 120) and framebuffer depth/address width
//     - colour width
//     - scan FSM state encoding
//     - pixel_addr(): raster address without a multiplier
// -----------------------------------------------------------------------------
package pixel_sink_pkg;

  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int FB_DEPTH   = SCREEN_W * SCREEN_H;  // 19200
  localparam int FB_ADDR_W  = 15;
  localparam int COLOUR_W   = 3;

  // Scan FSM encoding
  localparam logic [1:0] SCAN_IDLE   = 2'd0;
  localparam logic [1:0] SCAN_PRIME  = 2'd1;
  localparam logic [1:0] SCAN_STREAM = 2'd2;
  localparam logic [1:0] SCAN_DONE   = 2'd3;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  // y*160 + x written as y*128 + y*32 + x so it maps onto adders only.
  function automatic fb_addr_t pixel_addr(input logic [7:0] x, input logic [6:0] y);
    fb_addr_t y_ext;
    fb_addr_t x_ext;
    y_ext = {8'd0, y};
    x_ext = {7'd0, x};
    return (y_ext << 7) + (y_ext << 5) + x_ext;
  endfunction

endpackage

// File: rtl/pixel_sink_fb_ram.sv
// -----------------------------------------------------------------------------
// fb_ram
//   Simple dual-port framebuffer memory: one write port, one read port,
//   synchronous read with one cycle of latency. On a same-address collision
//   the read returns the previous contents (read-first).
//   Contents start at zero from configuration; no reset touches the array.
//
//   Ports:
//     clk    in   clock
//     we     in   write enable
//     waddr  in   write address
//     wdata  in   write data
//     re     in   read enable; rdata only changes on a read
//     raddr  in   read address
//     rdata  out  registered read data
// -----------------------------------------------------------------------------
module fb_ram
  import pixel_sink_pkg::*;
#(
  parameter int DEPTH  = FB_DEPTH,
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = COLOUR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  // Declaration initialiser gives the power-up (bitstream) contents.
  logic [DATA_W-1:0] mem [0:DEPTH-1] = '{default: '0};
  logic [DATA_W-1:0] rdata_q;

  // Both updates are non-blocking, so a read of the address being written
  // in the same cycle sees the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pixel_sink.sv
// -----------------------------------------------------------------------------
// pixel_sink
//   Captures the pixel-write stream (x, y, colour, drawEn) into a 160x120
//   framebuffer and, on request, streams the whole frame back out in raster
//   order over a valid/ready handshake.
//
//   Ports:
//     clk         in   clock, everything on posedge
//     reset       in   synchronous, active-low
//     drawEn      in   write strobe for xin/yin/colourIn
//     xin, yin    in   write coordinate
//     colourIn    in   write colour
//     scanStart   in   start a full-frame scan (only honoured when idle)
//     pixelReady  in   consumer accepts the presented pixel
//     pixelValid  out  pixelOut/xScan/yScan are valid
//     pixelOut    out  scanned colour
//     xScan,yScan out  coordinate of the presented pixel
//     scanDone    out  one-cycle pulse after the last pixel is accepted
//     busy        out  scan FSM not idle
//     dropCount   out  saturating count of out-of-range writes
// -----------------------------------------------------------------------------
module pixel_sink #(
  parameter int X_SCREEN_PIXELS = 160,
  parameter int Y_SCREEN_PIXELS = 120,
  parameter int COLOUR_W        = 3,
  parameter int DROP_W          = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                drawEn,
  input  logic [7:0]          xin,
  input  logic [6:0]          yin,
  input  logic [COLOUR_W-1:0] colourIn,
  input  logic                scanStart,
  input  logic                pixelReady,
  output logic                pixelValid,
  output logic [COLOUR_W-1:0] pixelOut,
  output logic [7:0]          xScan,
  output logic [6:0]          yScan,
  output logic                scanDone,
  output logic                busy,
  output logic [DROP_W-1:0]   dropCount
);

  import pixel_sink_pkg::*;

  localparam logic [7:0] X_LIM  = 8'(X_SCREEN_PIXELS);
  localparam logic [6:0] Y_LIM  = 7'(Y_SCREEN_PIXELS);
  localparam logic [7:0] X_LAST = 8'(X_SCREEN_PIXELS - 1);
  localparam logic [6:0] Y_LAST = 7'(Y_SCREEN_PIXELS - 1);

  // ---------------------------------------------------------------------------
  // Write path: stage 1 registers the qualified request, stage 2 is the RAM
  // write itself. It never looks at the scan FSM.
  // ---------------------------------------------------------------------------
  logic                in_range;
  logic                wr_valid_d, wr_valid_q;
  fb_addr_t            wr_addr_d,  wr_addr_q;
  logic [COLOUR_W-1:0] wr_colour_d, wr_colour_q;
  logic [DROP_W-1:0]   drop_d, drop_q;
  logic                ram_we;

  always_comb begin
    in_range    = (xin < X_LIM) && (yin < Y_LIM);
    wr_valid_d  = drawEn && in_range;
    wr_addr_d   = pixel_addr(xin, yin);
    wr_colour_d = colourIn;

    drop_d = drop_q;
    if (drawEn && !in_range && (drop_q != '1)) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_valid_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      wr_valid_q <= wr_valid_d;
      drop_q     <= drop_d;
    end
    wr_addr_q   <= wr_addr_d;
    wr_colour_q <= wr_colour_d;
  end

  // A write already in stage 1 when reset arrives is dropped, not committed.
  assign ram_we = wr_valid_q && reset;

  // ---------------------------------------------------------------------------
  // Scan FSM
  // scan_addr_q always tracks the raster address of (scan_x_q, scan_y_q), so
  // the read address for the next pixel is a plain increment.
  // ---------------------------------------------------------------------------
  logic [1:0]          state_d, state_q;
  logic [7:0]          scan_x_d, scan_x_q;
  logic [6:0]          scan_y_d, scan_y_q;
  fb_addr_t            scan_addr_d, scan_addr_q;
  logic                rd_en;
  fb_addr_t            rd_addr;
  logic [COLOUR_W-1:0] rd_data;
  logic                last_pixel;

  always_comb begin
    state_d     = state_q;
    scan_x_d    = scan_x_q;
    scan_y_d    = scan_y_q;
    scan_addr_d = scan_addr_q;
    rd_en       = 1'b0;
    rd_addr     = scan_addr_q;
    last_pixel  = (scan_x_q == X_LAST) && (scan_y_q == Y_LAST);

    case (state_q)
      SCAN_IDLE: begin
        if (scanStart) begin
          state_d = SCAN_PRIME;
        end
      end

      SCAN_PRIME: begin
        // Fetch pixel 0 so it is on rd_data when STREAM begins.
        rd_en   = 1'b1;
        rd_addr = '0;
        state_d = SCAN_STREAM;
      end

      SCAN_STREAM: begin
        if (pixelReady) begin
          if (last_pixel) begin
            state_d     = SCAN_DONE;
            scan_x_d    = '0;
            scan_y_d    = '0;
            scan_addr_d = '0;
          end else begin
            // Issue the next read in the transfer cycle: no bubble.
            rd_en       = 1'b1;
            rd_addr     = scan_addr_q + FB_ADDR_W'(1);
            scan_addr_d = scan_addr_q + FB_ADDR_W'(1);
            if (scan_x_q == X_LAST) begin
              scan_x_d = '0;
              scan_y_d = scan_y_q + 7'd1;
            end else begin
              scan_x_d = scan_x_q + 8'd1;
            end
          end
        end
        // Stalled: no read issued, so rd_data holds even if the pixel
        // being presented is rewritten meanwhile.
      end

      SCAN_DONE: begin
        state_d = SCAN_IDLE;
      end

      default: begin
        state_d = SCAN_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= SCAN_IDLE;
      scan_x_q    <= '0;
      scan_y_q    <= '0;
      scan_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      scan_x_q    <= scan_x_d;
      scan_y_q    <= scan_y_d;
      scan_addr_q <= scan_addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Framebuffer
  // ---------------------------------------------------------------------------
  fb_ram #(
    .DEPTH  (FB_DEPTH),
    .ADDR_W (FB_ADDR_W),
    .DATA_W (COLOUR_W)
  ) u_fb_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_addr_q),
    .wdata (wr_colour_q),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // ---------------------------------------------------------------------------
  // Outputs. The RAM output register is not reset, so pixelOut is forced to
  // zero outside STREAM to give a clean value after reset.
  // ---------------------------------------------------------------------------
  assign pixelValid = (state_q == SCAN_STREAM);
  assign pixelOut   = pixelValid ? rd_data : '0;
  assign xScan      = scan_x_q;
  assign yScan      = scan_y_q;
  assign scanDone   = (state_q == SCAN_DONE);
  assign busy       = (state_q != SCAN_IDLE);
  assign dropCount  = drop_q;

endmodule
